// File: rtl/cp0_exc_seq_if.sv
// Handshake and CP0 port bundle between the control unit, the exception
// sequencer and the CP0 register file.
interface cp0_exc_seq_if;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        eret_req;
  logic        busy;
  logic        done;
  logic [31:0] target_pc;
  logic [4:0]  cp0_raddr;
  logic        cp0_r;
  logic [31:0] cp0_rdata;
  logic [4:0]  cp0_waddr;
  logic        cp0_w;
  logic [31:0] cp0_wdata;

  // Sequencer side: consumes requests and read data, drives the CP0 port.
  modport master (
    input  exc_req, exc_code, exc_pc, eret_req, cp0_rdata,
    output busy, done, target_pc, cp0_raddr, cp0_r, cp0_waddr, cp0_w, cp0_wdata
  );

  // Environment side: control unit plus CP0 register file.
  modport slave (
    output exc_req, exc_code, exc_pc, eret_req, cp0_rdata,
    input  busy, done, target_pc, cp0_raddr, cp0_r, cp0_waddr, cp0_w, cp0_wdata
  );
endinterface

// File: rtl/cp0_exc_seq.sv
// Exception entry / eret sequencer: walks CP0 Status, Cause and EPC one
// access per cycle and reports the next PC with a one-cycle done pulse.
module cp0_exc_seq #(
  parameter logic [31:0] EXC_ENTRY = 32'h0040_0004
) (
  input  logic          clk,
  input  logic          rst,
  cp0_exc_seq_if.master bus
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  typedef enum logic [3:0] {
    IDLE,
    X_RD_ST,
    X_WR_ST,
    X_WR_CAUSE,
    X_WR_EPC,
    R_RD_ST,
    R_WR_ST,
    R_RD_EPC,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      status_q <= '0;
      code_q   <= '0;
      pc_q     <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      code_q   <= code_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  // Next-state logic; bus outputs depend only on state and holding registers,
  // so an asynchronous reset of state_q drops every strobe immediately.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    status_d      = status_q;
    code_d        = code_q;
    pc_d          = pc_q;
    target_d      = target_q;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.cp0_r     = 1'b0;
    bus.cp0_raddr = '0;
    bus.cp0_w     = 1'b0;
    bus.cp0_waddr = '0;
    bus.cp0_wdata = '0;

    unique case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.exc_req) begin
          code_d  = bus.exc_code;
          pc_d    = bus.exc_pc;
          state_d = X_RD_ST;
        end else if (bus.eret_req) begin
          state_d = R_RD_ST;
        end
      end
      X_RD_ST: begin
        bus.cp0_r     = 1'b1;
        bus.cp0_raddr = ADDR_STATUS;
        status_d      = bus.cp0_rdata;
        state_d       = X_WR_ST;
      end
      X_WR_ST: begin
        bus.cp0_w     = 1'b1;
        bus.cp0_waddr = ADDR_STATUS;
        bus.cp0_wdata = {status_q[26:0], 5'b0};
        state_d       = X_WR_CAUSE;
      end
      X_WR_CAUSE: begin
        bus.cp0_w     = 1'b1;
        bus.cp0_waddr = ADDR_CAUSE;
        bus.cp0_wdata = {25'b0, code_q, 2'b0};
        state_d       = X_WR_EPC;
      end
      X_WR_EPC: begin
        bus.cp0_w     = 1'b1;
        bus.cp0_waddr = ADDR_EPC;
        bus.cp0_wdata = pc_q;
        target_d      = EXC_ENTRY;
        state_d       = DONE;
      end
      R_RD_ST: begin
        bus.cp0_r     = 1'b1;
        bus.cp0_raddr = ADDR_STATUS;
        status_d      = bus.cp0_rdata;
        state_d       = R_WR_ST;
      end
      R_WR_ST: begin
        bus.cp0_w     = 1'b1;
        bus.cp0_waddr = ADDR_STATUS;
        bus.cp0_wdata = {5'b0, status_q[31:5]};
        state_d       = R_RD_EPC;
      end
      R_RD_EPC: begin
        bus.cp0_r     = 1'b1;
        bus.cp0_raddr = ADDR_EPC;
        target_d      = bus.cp0_rdata;
        state_d       = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.target_pc = target_q;

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Directed bench for cp0_exc_seq with a small CP0 register-file model that
// writes on the negedge and reads combinationally.
module tb_cp0_exc_seq;

  logic clk;
  logic rst;

  cp0_exc_seq_if bus ();

  cp0_exc_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // CP0 model plus activity counters, all owned by one process.
  logic [31:0] cp0_regs [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;
  int          n_wr;
  int          n_rd;
  int          n_done;

  assign bus.cp0_rdata = bus.cp0_r ? cp0_regs[bus.cp0_raddr] : 32'h0;

  initial begin
    for (int i = 0; i < 32; i++) cp0_regs[i] = 32'h0;
    n_wr   = 0;
    n_rd   = 0;
    n_done = 0;
  end

  always @(negedge clk) begin
    if (pre_we) cp0_regs[pre_addr] = pre_data;
    if (bus.cp0_w) begin
      cp0_regs[bus.cp0_waddr] = bus.cp0_wdata;
      n_wr++;
    end
    if (bus.cp0_r) n_rd++;
    if (bus.done) n_done++;
  end

  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load a CP0 register through the model's negedge port, then realign.
  task automatic preload(input logic [4:0] addr, input logic [31:0] data);
    pre_addr = addr;
    pre_data = data;
    pre_we   = 1'b1;
    @(negedge clk);
    #1;
    pre_we = 1'b0;
    step();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"},  {31'b0, bus.busy},  32'h0);
    check({tag, ".done"},  {31'b0, bus.done},  32'h0);
    check({tag, ".r"},     {31'b0, bus.cp0_r}, 32'h0);
    check({tag, ".w"},     {31'b0, bus.cp0_w}, 32'h0);
    check({tag, ".raddr"}, {27'b0, bus.cp0_raddr}, 32'h0);
    check({tag, ".waddr"}, {27'b0, bus.cp0_waddr}, 32'h0);
    check({tag, ".wdata"}, bus.cp0_wdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  int wr0, rd0, dn0;

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    pre_we       = 1'b0;
    pre_addr     = '0;
    pre_data     = '0;
    bus.exc_req  = 1'b0;
    bus.exc_code = '0;
    bus.exc_pc   = '0;
    bus.eret_req = 1'b0;

    // Reset state
    repeat (2) step();
    check_quiet("rst");
    check("rst.target", bus.target_pc, 32'h0);
    rst = 1'b0;

    // Idle for 20 cycles: no CP0 strobes
    wr0 = n_wr;
    rd0 = n_rd;
    repeat (20) step();
    check("idle.writes", n_wr - wr0, 0);
    check("idle.reads",  n_rd - rd0, 0);
    check("idle.busy", {31'b0, bus.busy}, 32'h0);

    // Syscall entry
    preload(5'd12, 32'h0000_001F);
    bus.exc_req  = 1'b1;
    bus.exc_code = 5'd8;
    bus.exc_pc   = 32'h0040_0020;
    step();
    bus.exc_req = 1'b0;
    check("sys.c1.busy", {31'b0, bus.busy}, 32'h1);
    check("sys.c1.r", {31'b0, bus.cp0_r}, 32'h1);
    check("sys.c1.raddr", {27'b0, bus.cp0_raddr}, 32'd12);
    step();
    check("sys.c2.w", {31'b0, bus.cp0_w}, 32'h1);
    check("sys.c2.waddr", {27'b0, bus.cp0_waddr}, 32'd12);
    check("sys.c2.wdata", bus.cp0_wdata, 32'h0000_03E0);
    step();
    check("sys.c3.waddr", {27'b0, bus.cp0_waddr}, 32'd13);
    check("sys.c3.wdata", bus.cp0_wdata, 32'h0000_0020);
    step();
    check("sys.c4.waddr", {27'b0, bus.cp0_waddr}, 32'd14);
    check("sys.c4.wdata", bus.cp0_wdata, 32'h0040_0020);
    check("sys.c4.done", {31'b0, bus.done}, 32'h0);
    step();
    check("sys.c5.done", {31'b0, bus.done}, 32'h1);
    check("sys.c5.busy", {31'b0, bus.busy}, 32'h1);
    check("sys.c5.w", {31'b0, bus.cp0_w}, 32'h0);
    check("sys.c5.target", bus.target_pc, 32'h0040_0004);
    step();
    check("sys.end.done", {31'b0, bus.done}, 32'h0);
    check("sys.end.busy", {31'b0, bus.busy}, 32'h0);
    check("sys.status", cp0_regs[12], 32'h0000_03E0);
    check("sys.cause",  cp0_regs[13], 32'h0000_0020);
    check("sys.epc",    cp0_regs[14], 32'h0040_0020);

    // Eret from the syscall
    bus.eret_req = 1'b1;
    step();
    bus.eret_req = 1'b0;
    check("eret.c1.r", {31'b0, bus.cp0_r}, 32'h1);
    check("eret.c1.raddr", {27'b0, bus.cp0_raddr}, 32'd12);
    step();
    check("eret.c2.w", {31'b0, bus.cp0_w}, 32'h1);
    check("eret.c2.wdata", bus.cp0_wdata, 32'h0000_001F);
    step();
    check("eret.c3.raddr", {27'b0, bus.cp0_raddr}, 32'd14);
    check("eret.c3.done", {31'b0, bus.done}, 32'h0);
    step();
    check("eret.c4.done", {31'b0, bus.done}, 32'h1);
    check("eret.c4.target", bus.target_pc, 32'h0040_0020);
    step();
    check("eret.status", cp0_regs[12], 32'h0000_001F);
    check("eret.target_hold", bus.target_pc, 32'h0040_0020);

    // Reset while idle clears target_pc
    rst = 1'b1;
    #1;
    check_quiet("idle_rst");
    check("idle_rst.target", bus.target_pc, 32'h0);
    step();
    rst = 1'b0;

    // Priority: exception wins; eret pulse during busy is ignored
    preload(5'd12, 32'h0000_0003);
    wr0 = n_wr;
    rd0 = n_rd;
    dn0 = n_done;
    bus.exc_req  = 1'b1;
    bus.eret_req = 1'b1;
    bus.exc_code = 5'd9;
    bus.exc_pc   = 32'h0040_0200;
    step();
    bus.exc_req  = 1'b0;
    bus.eret_req = 1'b0;
    step();
    bus.eret_req = 1'b1;
    step();
    bus.eret_req = 1'b0;
    check("prio.c3.w", {31'b0, bus.cp0_w}, 32'h1);
    check("prio.c3.waddr", {27'b0, bus.cp0_waddr}, 32'd13);
    repeat (5) step();
    check("prio.writes", n_wr - wr0, 3);
    check("prio.reads",  n_rd - rd0, 1);
    check("prio.dones",  n_done - dn0, 1);
    check("prio.busy", {31'b0, bus.busy}, 32'h0);
    check("prio.status", cp0_regs[12], 32'h0000_0060);
    check("prio.cause",  cp0_regs[13], 32'h0000_0024);
    check("prio.epc",    cp0_regs[14], 32'h0040_0200);
    check("prio.target", bus.target_pc, 32'h0040_0004);

    // Truncation on teq
    preload(5'd12, 32'hF800_0001);
    bus.exc_req  = 1'b1;
    bus.exc_code = 5'd13;
    bus.exc_pc   = 32'h0040_0100;
    step();
    bus.exc_req = 1'b0;
    repeat (5) step();
    check("teq.status", cp0_regs[12], 32'h0000_0020);
    check("teq.cause",  cp0_regs[13], 32'h0000_0034);
    check("teq.epc",    cp0_regs[14], 32'h0040_0100);

    // Reset during X_WR_CAUSE aborts the sequence
    preload(5'd14, 32'hDEAD_BEEF);
    dn0 = n_done;
    bus.exc_req  = 1'b1;
    bus.exc_code = 5'd8;
    bus.exc_pc   = 32'h0040_0300;
    step();
    bus.exc_req = 1'b0;
    step();
    step();
    check("abort.c3.w", {31'b0, bus.cp0_w}, 32'h1);
    check("abort.c3.waddr", {27'b0, bus.cp0_waddr}, 32'd13);
    #1;
    rst = 1'b1;
    #1;
    check_quiet("abort.rst");
    wr0 = n_wr;
    repeat (2) step();
    rst = 1'b0;
    repeat (6) step();
    check("abort.writes", n_wr - wr0, 0);
    check("abort.epc", cp0_regs[14], 32'hDEAD_BEEF);
    check("abort.dones", n_done - dn0, 0);
    check("abort.busy", {31'b0, bus.busy}, 32'h0);

    // Fresh eret after the abort starts from IDLE
    bus.eret_req = 1'b1;
    step();
    bus.eret_req = 1'b0;
    check("restart.c1.raddr", {27'b0, bus.cp0_raddr}, 32'd12);
    repeat (3) step();
    check("restart.done", {31'b0, bus.done}, 32'h1);
    check("restart.target", bus.target_pc, 32'hDEAD_BEEF);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
